// File: rtl/aurora_reset_pkg.sv
// Shared definitions for the Aurora reset sequencer: state encoding,
// default cycle counts and a counter-width helper.
package aurora_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET_ALL    = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_SYS_HOLD     = 3'd2,
    ST_WAIT_CHANNEL = 3'd3,
    ST_RUNNING      = 3'd4,
    ST_FAULT        = 3'd5
  } state_e;

  localparam int DEF_GT_RESET_CYCLES    = 128;
  localparam int DEF_LOCK_STABLE_CYCLES = 64;
  localparam int DEF_SYS_RESET_CYCLES   = 256;
  localparam int DEF_TIMEOUT_CYCLES     = 1048576;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aurora_reset_seq_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with asynchronous active-low reset.
// Ports:
//   clk   - destination clock
//   rst_n - async active-low reset, both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (2 cycles latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_reset_seq.sv
// aurora_reset_seq: reset sequencer for one Aurora link on INIT_CLK.
// Holds the GT in reset, waits for a stable MMCM lock, holds the core
// reset a while longer, then supervises CHANNEL_UP with timeout recovery.
// Optional feature: define AURORA_RESET_SEQ_AUTO_RETRY_EN to make timeouts
// restart the sequence (counted in RETRY_COUNT) instead of parking in FAULT.
// Ports:
//   INIT_CLK, RESET_N      - clock, async active-low reset
//   RESET_REQ              - sync restart request (one-cycle pulse enough)
//   MMCM_NOT_LOCKED        - async, high while MMCM unlocked
//   CHANNEL_UP             - async, Aurora channel up
//   GT_RESET, SYS_RESET    - active-high transceiver / core resets
//   READY, FAULT           - high in RUNNING / FAULT
//   STATE                  - current state encoding
//   RETRY_COUNT            - automatic re-sequences, saturating at 255
module aurora_reset_seq
  import aurora_reset_pkg::*;
#(
  parameter int GT_RESET_CYCLES    = DEF_GT_RESET_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int SYS_RESET_CYCLES   = DEF_SYS_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
  input  logic       INIT_CLK,
  input  logic       RESET_N,
  input  logic       RESET_REQ,
  input  logic       MMCM_NOT_LOCKED,
  input  logic       CHANNEL_UP,
  output logic       GT_RESET,
  output logic       SYS_RESET,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [7:0] RETRY_COUNT
);

  localparam int TW = cnt_w(max3(GT_RESET_CYCLES, SYS_RESET_CYCLES, TIMEOUT_CYCLES));
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] GT_LAST   = TW'(GT_RESET_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(SYS_RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_N  = SW'(LOCK_STABLE_CYCLES);

`ifdef AURORA_RESET_SEQ_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  state_e        state, nxt;
  logic [TW-1:0] cnt;
  logic [SW-1:0] stable;
  logic          not_locked_s, locked_s, up_s;
  logic          retry_inc, timeout;
  logic          gt_n, sys_n, ready_n, fault_n;

  // MMCM sync resets to "unlocked", channel sync to "down".
  sync_2ff #(.RST_VAL(1'b1)) u_sync_lock (
    .clk(INIT_CLK), .rst_n(RESET_N), .d(MMCM_NOT_LOCKED), .q(not_locked_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_up (
    .clk(INIT_CLK), .rst_n(RESET_N), .d(CHANNEL_UP), .q(up_s));

  assign locked_s = !not_locked_s;
  assign timeout  = (cnt == TO_LAST);

  // State register plus the counters that follow it.
  always_ff @(posedge INIT_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_RESET_ALL;
      cnt         <= '0;
      stable      <= '0;
      RETRY_COUNT <= '0;
    end else begin
      state <= nxt;
      // State-time counter restarts on every entry (and on RESET_REQ,
      // which may re-enter RESET_ALL from RESET_ALL); saturates otherwise.
      if (RESET_REQ || nxt != state) cnt <= '0;
      else if (cnt != '1)            cnt <= cnt + 1'b1;
      // Consecutive-lock counter only live in WAIT_LOCK.
      if (RESET_REQ || state != ST_WAIT_LOCK || !locked_s) stable <= '0;
      else if (stable != STABLE_N)                         stable <= stable + 1'b1;
      if (retry_inc && RETRY_COUNT != 8'hFF) RETRY_COUNT <= RETRY_COUNT + 8'd1;
    end
  end

  // Next state. Order of tests encodes priority: request, unlock, timeout, progress.
  always_comb begin
    nxt       = state;
    retry_inc = 1'b0;
    if (RESET_REQ) begin
      nxt = ST_RESET_ALL;
    end else begin
      case (state)
        ST_RESET_ALL:
          if (cnt == GT_LAST) nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (timeout) begin
            if (AUTO_RETRY) begin nxt = ST_RESET_ALL; retry_inc = 1'b1; end
            else nxt = ST_FAULT;
          end else if (stable == STABLE_N && locked_s) nxt = ST_SYS_HOLD;
        ST_SYS_HOLD:
          if (!locked_s)            nxt = ST_WAIT_LOCK;
          else if (cnt == HOLD_LAST) nxt = ST_WAIT_CHANNEL;
        ST_WAIT_CHANNEL:
          if (!locked_s) begin
            nxt = ST_RESET_ALL; retry_inc = 1'b1;
          end else if (timeout) begin
            if (AUTO_RETRY) begin nxt = ST_RESET_ALL; retry_inc = 1'b1; end
            else nxt = ST_FAULT;
          end else if (up_s) nxt = ST_RUNNING;
        ST_RUNNING:
          if (!locked_s) begin
            nxt = ST_RESET_ALL; retry_inc = 1'b1;
          end else if (!up_s) nxt = ST_WAIT_CHANNEL;
        ST_FAULT: nxt = ST_FAULT;
        default:  nxt = ST_RESET_ALL;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    gt_n    = 1'b0;
    sys_n   = 1'b0;
    ready_n = 1'b0;
    fault_n = 1'b0;
    case (nxt)
      ST_RESET_ALL: begin gt_n = 1'b1; sys_n = 1'b1; end
      ST_WAIT_LOCK,
      ST_SYS_HOLD:  sys_n = 1'b1;
      ST_RUNNING:   ready_n = 1'b1;
      ST_FAULT:     begin gt_n = 1'b1; sys_n = 1'b1; fault_n = 1'b1; end
      default:      ;
    endcase
  end

  always_ff @(posedge INIT_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      GT_RESET  <= 1'b1;
      SYS_RESET <= 1'b1;
      READY     <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      GT_RESET  <= gt_n;
      SYS_RESET <= sys_n;
      READY     <= ready_n;
      FAULT     <= fault_n;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_aurora_reset_seq.sv
// Directed bench for aurora_reset_seq with short cycle parameters.
module tb_aurora_reset_seq;

  logic       init_clk, reset_n, reset_req, mmcm_not_locked, channel_up;
  logic       gt_reset, sys_reset, ready, fault;
  logic [2:0] state;
  logic [7:0] retry_count;

  int n_pass = 0;
  int n_chk  = 0;
  int n;

`ifdef AURORA_RESET_SEQ_AUTO_RETRY_EN
  localparam int RETRY_T5 = 255;
`else
  localparam int RETRY_T5 = 1;
`endif

  aurora_reset_seq #(
    .GT_RESET_CYCLES(8), .LOCK_STABLE_CYCLES(4),
    .SYS_RESET_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .INIT_CLK(init_clk), .RESET_N(reset_n), .RESET_REQ(reset_req),
    .MMCM_NOT_LOCKED(mmcm_not_locked), .CHANNEL_UP(channel_up),
    .GT_RESET(gt_reset), .SYS_RESET(sys_reset), .READY(ready), .FAULT(fault),
    .STATE(state), .RETRY_COUNT(retry_count)
  );

  initial init_clk = 1'b0;
  always #5 init_clk = ~init_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge init_clk);
    #1;
  endtask

  // Poll until STATE == s (first observation is just after the entry edge).
  task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while (state !== s && k < lim) begin tick(); k++; end
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    reset_n = 1'b0; reset_req = 1'b0; mmcm_not_locked = 1'b0; channel_up = 1'b1;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_gt", gt_reset, 1);
    chk("rst_sys", sys_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);

    // 1: bring-up with lock and channel already good
    reset_n = 1'b1;
    n = 0; while (gt_reset && n < 50) begin tick(); n++; end
    chk("gt_hold_cycles", n, 8);
    n = 0; while (sys_reset && n < 100) begin tick(); n++; end
    chk("sys_fall_21to23", (n >= 21 && n <= 23), 1);
    n = 0; while (!ready && n < 20) begin tick(); n++; end
    chk("ready_rise_1to2", (n >= 1 && n <= 2), 1);
    chk("run_state", state, 4);
    chk("run_retry", retry_count, 0);

    // 3: unlock in RUNNING restarts after sync latency
    mmcm_not_locked = 1'b1;
    repeat (3) tick();
    chk("unlock_state", state, 0);
    chk("unlock_gt", gt_reset, 1);
    chk("unlock_ready", ready, 0);
    chk("unlock_retry", retry_count, 1);

    // 2: broken lock run restarts the stable counter
    wait_state("enter_wait_lock", 1, 50);
    mmcm_not_locked = 1'b0;
    repeat (3) tick();
    mmcm_not_locked = 1'b1;
    tick();
    mmcm_not_locked = 1'b0;
    repeat (4) tick();
    chk("lock_restart_a", state, 1);
    repeat (2) tick();
    chk("lock_restart_b", state, 1);
    tick();
    chk("lock_run_done", state, 2);

    // lock glitch in SYS_HOLD falls back to WAIT_LOCK, no retry
    repeat (3) tick();
    mmcm_not_locked = 1'b1;
    tick();
    mmcm_not_locked = 1'b0;
    repeat (2) tick();
    chk("hold_drop_state", state, 1);
    chk("hold_drop_retry", retry_count, 1);
    wait_state("back_to_run", 4, 200);

    // 4: channel never comes up
    channel_up = 1'b0;
    wait_state("chan_drop", 3, 10);
    repeat (99) tick();
    chk("to_not_yet", state, 3);
    tick();
`ifdef AURORA_RESET_SEQ_AUTO_RETRY_EN
    chk("to_state", state, 0);
    chk("to_retry", retry_count, 2);
    chk("to_fault", fault, 0);
    n = 0; while (retry_count != 8'd255 && n < 40000) begin tick(); n++; end
    chk("retry_reach_255", retry_count, 255);
    wait_state("sat_wait_chan", 3, 200);
    repeat (100) tick();
    chk("sat_state", state, 0);
    chk("sat_retry", retry_count, 255);
`else
    chk("to_state", state, 5);
    chk("to_fault", fault, 1);
    chk("to_gt", gt_reset, 1);
    chk("to_sys", sys_reset, 1);
    chk("to_ready", ready, 0);
    chk("to_retry", retry_count, 1);
    repeat (5) tick();
    chk("fault_sticky", state, 5);
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("req_clr_state", state, 0);
    chk("req_clr_fault", fault, 0);
`endif

    // 5: RESET_REQ on the timeout edge wins
    wait_state("t5_wait_chan", 3, 200);
    repeat (99) tick();
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("req_to_state", state, 0);
    chk("req_to_retry", retry_count, RETRY_T5);
    chk("req_to_fault", fault, 0);
    chk("req_to_gt", gt_reset, 1);

    // 6: async reset mid-SYS_HOLD, no clock edge
    wait_state("t6_hold", 2, 200);
    repeat (5) tick();
    chk("t6_pre_gt", gt_reset, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_gt", gt_reset, 1);
    chk("arst_sys", sys_reset, 1);
    chk("arst_ready", ready, 0);
    chk("arst_fault", fault, 0);
    chk("arst_retry", retry_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
